// File: rtl/nes_operand_ctrl_if.sv
// Button-frame inputs and operand/display outputs between the controller
// reader, the operand editor and the add/sub datapath.
interface nes_operand_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             frame_valid;
    logic             up;
    logic             down;
    logic             left;
    logic             right;
    logic             select;
    logic             a_but;
    logic             b_but;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sub_sel;
    logic             edit_b;
    logic             result_valid;

    modport master (
        output frame_valid, up, down, left, right, select, a_but, b_but,
        input  op_a, op_b, cin, sub_sel, edit_b, result_valid
    );

    modport slave (
        input  frame_valid, up, down, left, right, select, a_but, b_but,
        output op_a, op_b, cin, sub_sel, edit_b, result_valid
    );
endinterface

// File: rtl/nes_operand_ctrl.sv
// Operand editor for the NES add/sub demo: edge-detects per-frame buttons and
// dials in A/B, add/sub mode and result display. NES_OPERAND_AUTOREPEAT_EN adds held-direction repeat.
//
// state  | meaning
// EDIT_A | up/down adjust operand A, right moves to B, A button shows result
// EDIT_B | up/down adjust operand B, left moves to A, A button shows result
// RESULT | operands frozen, B button returns to EDIT_A
module nes_operand_ctrl #(
    parameter int WIDTH       = 4,
    parameter int HOLD_FRAMES = 30,
    parameter int RPT_FRAMES  = 6
) (
    input logic                clk,
    input logic                reset_n,
    nes_operand_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        EDIT_A = 2'd0,
        EDIT_B = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int P_UP  = 6;
    localparam int P_DN  = 5;
    localparam int P_LT  = 4;
    localparam int P_RT  = 3;
    localparam int P_SEL = 2;
    localparam int P_A   = 1;
    localparam int P_B   = 0;

    if (HOLD_FRAMES < 1 || RPT_FRAMES < 1) begin : g_bad_cfg
        $error("nes_operand_ctrl: HOLD_FRAMES and RPT_FRAMES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sub_q, sub_d;
    logic [6:0]       prev_q;
    logic [6:0]       btn;
    logic [6:0]       press;
    logic             inc, dec;
    logic             rpt_up, rpt_dn;

    assign btn   = {bus.up, bus.down, bus.left, bus.right, bus.select, bus.a_but, bus.b_but};
    assign press = btn & ~prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EDIT_A;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            prev_q  <= '0;
        end else if (bus.frame_valid) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            prev_q  <= btn;
        end
    end

    // Operand step uses the state before any move decided in the same frame.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        inc     = 1'b0;
        dec     = 1'b0;
        if (bus.frame_valid) begin
            if (press[P_SEL]) sub_d = ~sub_q;
            unique case (state_q)
                EDIT_A, EDIT_B: begin
                    if (press[P_A]) begin
                        state_d = RESULT;
                    end else begin
                        inc = (press[P_UP] & ~press[P_DN]) | rpt_up;
                        dec = (press[P_DN] & ~press[P_UP]) | rpt_dn;
                        if (state_q == EDIT_A) begin
                            if (inc)      a_d = a_q + 1'b1;
                            else if (dec) a_d = a_q - 1'b1;
                            if (press[P_RT] && !press[P_LT]) state_d = EDIT_B;
                        end else begin
                            if (inc)      b_d = b_q + 1'b1;
                            else if (dec) b_d = b_q - 1'b1;
                            if (press[P_LT] && !press[P_RT]) state_d = EDIT_A;
                        end
                    end
                end
                RESULT: begin
                    if (press[P_B]) state_d = EDIT_A;
                end
                default: state_d = EDIT_A;
            endcase
        end
    end

`ifdef NES_OPERAND_AUTOREPEAT_EN
    localparam int TW = $clog2(((HOLD_FRAMES > RPT_FRAMES) ? HOLD_FRAMES : RPT_FRAMES) + 1);

    logic [TW-1:0] tmr_q;
    logic          arm_q;
    logic          held_up, held_dn, start, stay;

    assign held_up = btn[P_UP] & prev_q[P_UP] & ~btn[P_DN];
    assign held_dn = btn[P_DN] & prev_q[P_DN] & ~btn[P_UP];
    assign start   = (press[P_UP] & ~btn[P_DN]) | (press[P_DN] & ~btn[P_UP]);
    assign stay    = (state_q != RESULT) && (state_d == state_q);

    // Down-counter loaded on the press; terminal count emits one repeat step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q <= '0;
            arm_q <= 1'b0;
        end else if (bus.frame_valid) begin
            if (!stay) begin
                tmr_q <= '0;
                arm_q <= 1'b0;
            end else if (start) begin
                tmr_q <= TW'(HOLD_FRAMES - 1);
                arm_q <= 1'b1;
            end else if (arm_q && (held_up || held_dn)) begin
                if (tmr_q == '0) tmr_q <= TW'(RPT_FRAMES - 1);
                else             tmr_q <= tmr_q - 1'b1;
            end else begin
                tmr_q <= '0;
                arm_q <= 1'b0;
            end
        end
    end

    assign rpt_up = arm_q && held_up && (tmr_q == '0) && (state_q != RESULT);
    assign rpt_dn = arm_q && held_dn && (tmr_q == '0) && (state_q != RESULT);
`else
    assign rpt_up = 1'b0;
    assign rpt_dn = 1'b0;
`endif

    assign bus.op_a         = a_q;
    assign bus.op_b         = b_q;
    assign bus.sub_sel      = sub_q;
    assign bus.cin          = sub_q;
    assign bus.edit_b       = (state_q == EDIT_B);
    assign bus.result_valid = (state_q == RESULT);
endmodule

// File: tb/tb_nes_operand_ctrl.sv
// Self-checking bench for nes_operand_ctrl: directed vector table, corner
// sequences (hold, frame_valid low, async reset) and a randomized model run.
module tb_nes_operand_ctrl;
    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    localparam logic [6:0] N  = 7'h00;
    localparam logic [6:0] U  = 7'h40;
    localparam logic [6:0] D  = 7'h20;
    localparam logic [6:0] L  = 7'h10;
    localparam logic [6:0] R  = 7'h08;
    localparam logic [6:0] S  = 7'h04;
    localparam logic [6:0] A  = 7'h02;
    localparam logic [6:0] B  = 7'h01;

    typedef struct {
        logic [6:0] btn;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       es;
        logic       ee;
        logic       er;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int         m_a, m_b, m_st;
    logic       m_sub;
    logic [6:0] m_prev;
    vec_t       tbl[$];

    nes_operand_ctrl_if #(.WIDTH(WIDTH)) bif ();

    nes_operand_ctrl #(.WIDTH(WIDTH), .HOLD_FRAMES(30), .RPT_FRAMES(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] ea, input logic [3:0] eb,
                         input logic es, input logic ee, input logic er);
        logic [11:0] act, exp;
        act = {bif.op_a, bif.op_b, bif.sub_sel, bif.cin, bif.edit_b, bif.result_valid};
        exp = {ea, eb, es, es, ee, er};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got a=%h b=%h sub=%b cin=%b edit_b=%b rv=%b, want a=%h b=%h sub=%b cin=%b edit_b=%b rv=%b",
                     name, bif.op_a, bif.op_b, bif.sub_sel, bif.cin, bif.edit_b, bif.result_valid,
                     ea, eb, es, es, ee, er);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_a[3:0], m_b[3:0], m_sub, m_st == 1, m_st == 2);
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_st = 0; m_sub = 1'b0; m_prev = '0;
    endtask

    // Reference: per-frame press rules on integer operands and a numeric state.
    task automatic model_step(input logic [6:0] b);
        logic [6:0] p;
        int d;
        p = b & ~m_prev;
        m_prev = b;
        d = 0;
        if (p[2]) m_sub = !m_sub;
        if (m_st == 2) begin
            if (p[0]) m_st = 0;
        end else if (p[1]) begin
            m_st = 2;
        end else begin
            if (p[6] && !p[5]) d = 1;
            if (p[5] && !p[6]) d = -1;
            if (m_st == 0) m_a = (m_a + d + MOD) % MOD;
            else           m_b = (m_b + d + MOD) % MOD;
            if (m_st == 0 && p[3] && !p[4])      m_st = 1;
            else if (m_st == 1 && p[4] && !p[3]) m_st = 0;
        end
    endtask

    task automatic drive(input logic [6:0] b);
        bif.up = b[6]; bif.down = b[5]; bif.left = b[4]; bif.right = b[3];
        bif.select = b[2]; bif.a_but = b[1]; bif.b_but = b[0];
    endtask

    // Called at a negedge; the frame is sampled at the next posedge and
    // results are visible at the following negedge.
    task automatic frame(input logic [6:0] b, input logic fv);
        drive(b);
        bif.frame_valid = fv;
        @(negedge clk);
        bif.frame_valid = 1'b0;
        if (fv) model_step(b);
    endtask

    task automatic do_reset();
        bif.frame_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        drive(N);
        bif.frame_valid = 1'b0;
        model_reset();

        tbl.push_back('{U,     4'h1, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{N,     4'h1, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{U,     4'h2, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{D,     4'h1, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{N,     4'h1, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{D,     4'h0, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{N,     4'h0, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{D,     4'hF, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{N,     4'hF, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{U,     4'h0, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{R,     4'h0, 4'h0, 1'b0, 1'b1, 1'b0});
        for (int i = 1; i <= 5; i++) begin
            tbl.push_back('{U, 4'h0, 4'(i), 1'b0, 1'b1, 1'b0});
            if (i < 5) tbl.push_back('{N, 4'h0, 4'(i), 1'b0, 1'b1, 1'b0});
        end
        tbl.push_back('{L,     4'h0, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{S,     4'h0, 4'h5, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{N,     4'h0, 4'h5, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{S,     4'h0, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{N,     4'h0, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{U | D, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{N,     4'h0, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{R,     4'h0, 4'h5, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{N,     4'h0, 4'h5, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{L | R, 4'h0, 4'h5, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{N,     4'h0, 4'h5, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{L,     4'h0, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{U | R, 4'h1, 4'h5, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{N,     4'h1, 4'h5, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{L,     4'h1, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{U,     4'h2, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{N,     4'h2, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{U,     4'h3, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{N,     4'h3, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{A | U, 4'h3, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{N,     4'h3, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{U,     4'h3, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{N,     4'h3, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{D,     4'h3, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{N,     4'h3, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{B | S, 4'h3, 4'h5, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{N,     4'h3, 4'h5, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{B,     4'h3, 4'h5, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{A,     4'h3, 4'h5, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{N,     4'h3, 4'h5, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{S,     4'h3, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{R,     4'h3, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{B,     4'h3, 4'h5, 1'b0, 1'b0, 1'b0});

        @(negedge clk);
        @(negedge clk);
        check("reset_state", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            frame(tbl[i].btn, 1'b1);
            check($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].es, tbl[i].ee, tbl[i].er);
        end

        // Down-wrap from reset then back up, then frame_valid=0 must hold.
        do_reset();
        frame(D, 1'b1);
        check("wrap_down", 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        frame(N, 1'b1);
        frame(U, 1'b1);
        check("wrap_up", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        frame(N, 1'b1);
        frame(U | S | R, 1'b0);
        check("fv_low_hold", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        frame(U, 1'b1);
        check("after_fv_low", 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);

        // Up held across 10 back-to-back frames steps once.
        do_reset();
        for (int i = 0; i < 10; i++) frame(U, 1'b1);
        check("held_up", 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);

        // Button held through reset counts as a press on the first frame.
        drive(U);
        do_reset();
        frame(U, 1'b1);
        check("held_thru_reset", 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
        frame(S, 1'b1);
        check("pre_async", 4'h1, 4'h0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges.
        #2 reset_n = 1'b0;
        #1 check("async_reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        drive(N);

        for (int i = 0; i < 400; i++) begin
            logic [6:0] b;
            logic       fv;
            for (int k = 0; k < 7; k++) b[k] = ($urandom_range(0, 99) < 35);
            fv = ($urandom_range(0, 3) != 0);
            frame(b, fv);
            check_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
